sel_rr_scheduler: RTL and testbench
===================================

Name: sel_rr_scheduler

Overview:
- Clocked round-robin scheduler that shares the 32-way asynchronous selector among 32 requesters.
- Per transaction: picks one requester, presents a stable one-hot valid mask to the selector, and issues a 2-phase drive transition.
- Tracks the selector's free/completion transitions through synchronizers and returns a done pulse to the winner.
- Sits between the clocked replacement-policy logic and the click-based selector pipeline.

Parameters:
- DATA_WIDTH, 32: number of requesters and selector outputs.
- SYNC_STAGES, 2: flop stages on each asynchronous input (≥2).
- SETUP_CYCLES, 2: cycles o_valid is held stable before o_drive toggles (≥1).
- TIMEOUT, 255: max cycles in WAIT_FREE + WAIT_DONE before error; 8-bit counter.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-low reset.
- i_req  in  DATA_WIDTH  level request per requester.
- o_gnt  out  DATA_WIDTH  one-hot grant, held for the whole transaction.
- o_done  out  DATA_WIDTH  one-cycle one-hot completion pulse.
- o_valid  out  DATA_WIDTH  mask to selector valid; equals o_gnt while granted.
- o_drive  out  1  2-phase request to selector i_drive; toggles once per transaction.
- i_free  in  1  2-phase ack from selector o_free; asynchronous.
- i_freeNext  in  1  OR of selector-side downstream free; 2-phase, asynchronous.
- o_busy  out  1  high in any state other than IDLE.
- o_err  out  1  sticky timeout flag.
- i_clr  in  1  clears o_err; returns ERROR to IDLE.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, rr pointer=0, o_gnt=o_valid=o_done=0, o_drive=0, o_busy=0, o_err=0, counters 0. Synchronizer chains cleared; the expected phase of each input is reloaded from its synced value on the first cycle after reset release.
- Edge detect: an event is synced input != stored phase; on acceptance, stored phase := synced input.
- IDLE: if |i_req, go to ARB.
- ARB: winner = first set bit of i_req at or above the pointer, wrapping from 31 to 0. Register o_gnt = o_valid = one-hot(winner); go to SETUP. If i_req = 0 in ARB, return to IDLE with no grant.
- SETUP: o_valid held stable for SETUP_CYCLES cycles, then o_drive toggles; go to WAIT_FREE with the timeout counter at 0. o_valid never changes while o_drive is in flight; the selector fire is never used to qualify valid.
- WAIT_FREE: on an i_free event, go to WAIT_DONE. If the i_free and i_freeNext events arrive in the same cycle, accept both and go directly to COMPLETE.
- WAIT_DONE: on an i_freeNext event, go to COMPLETE.
- COMPLETE (one cycle):
  - o_done = o_gnt pulse; o_gnt and o_valid cleared.
  - pointer := (winner+1) mod DATA_WIDTH.
  - Go to IDLE, so back-to-back grants are separated by at least 1 IDLE cycle.
- Timeout: counter increments each cycle in WAIT_FREE/WAIT_DONE. At TIMEOUT, go to ERROR: o_err=1, o_gnt/o_valid cleared, no o_done, pointer unchanged. ERROR holds until i_clr=1; next cycle o_err=0, state IDLE, phases resampled.
- Request deasserted after grant: the transaction still completes and o_done still pulses.
- Events arriving in IDLE, ARB or SETUP are spurious: ignored (phase updated), no state change.
- Latency: i_req rises before edge k (IDLE):
  - o_gnt/o_valid visible after edge k+2.
  - o_drive toggles after edge k+2+SETUP_CYCLES.
  - o_done asserts 1 cycle after the i_freeNext event is seen at the synchronizer output.

Test Plan:
- Single request: i_req=0x0000_0008, selector model returns free then freeNext edges → o_valid=0x8 for ≥2 cycles before the o_drive 0→1 toggle; o_done=0x8 for exactly 1 cycle; pointer=4.
- Round-robin fairness: i_req=0xFFFF_FFFF held for 33 transactions → grants in order bit0, bit1, …, bit31, bit0; every grant one-hot; o_drive toggles 33 times.
- Wrap-around: pointer=31, i_req=0x8000_0001 → grant 0x8000_0000, then 0x0000_0001.
- Simultaneous edges: i_free and i_freeNext toggle in the same clock → WAIT_DONE skipped; o_done one cycle after the synced events.
- Timeout: selector model never toggles i_free → after 255 cycles o_err=1, o_valid=0, no o_done; pulse i_clr → o_err=0; next request served normally.
- Reset mid-transaction: assert rst in WAIT_DONE → all outputs 0 immediately (asynchronous); after release plus a stale i_freeNext toggle → no o_done; a new request completes normally from pointer 0.

Source files
------------

// File: rtl/sel_rr_scheduler.sv
// sel_rr_scheduler
//
// Clocked round-robin front end for the shared 32-way asynchronous selector.
// One requester is picked per transaction. Its one-hot mask is presented
// on o_valid and held stable for SETUP_CYCLES before o_drive issues a
// 2-phase request. The selector's 2-phase free / freeNext acknowledgements
// are synchronised, and the scheduler then returns a one-cycle done pulse to
// the winner. If the selector does not answer within TIMEOUT cycles, the
// scheduler parks in an error state until software clears it.
//
// Ports
//   clk          single clock
//   rst          asynchronous, active-low reset
//   i_req        level request, one bit per requester
//   o_gnt        one-hot grant, held for the whole transaction
//   o_done       one-cycle one-hot completion pulse to the winner
//   o_valid      valid mask to the selector (equals o_gnt while granted)
//   o_drive      2-phase request to the selector, toggles once per transaction
//   i_free       2-phase ack from the selector (asynchronous)
//   i_freeNext   2-phase downstream-free from the selector (asynchronous)
//   o_busy       high whenever the scheduler is not idle
//   o_err        sticky timeout flag
//   i_clr        clears o_err and returns the scheduler to idle

module sel_rr_scheduler #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned SETUP_CYCLES = 2,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] i_req,
    output logic [DATA_WIDTH-1:0] o_gnt,
    output logic [DATA_WIDTH-1:0] o_done,
    output logic [DATA_WIDTH-1:0] o_valid,
    output logic                  o_drive,
    input  logic                  i_free,
    input  logic                  i_freeNext,
    output logic                  o_busy,
    output logic                  o_err,
    input  logic                  i_clr
);

    localparam int unsigned PTR_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int unsigned SET_W = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;

    localparam logic [PTR_W-1:0] LAST_IDX   = PTR_W'(DATA_WIDTH - 1);
    localparam logic [SET_W-1:0] SETUP_LAST = SET_W'(SETUP_CYCLES - 1);
    localparam logic [7:0]       TMO_LIMIT  = 8'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ARB       = 3'd1,
        SETUP     = 3'd2,
        WAIT_FREE = 3'd3,
        WAIT_DONE = 3'd4,
        COMPLETE  = 3'd5,
        ERROR     = 3'd6
    } state_t;

    state_t                  state_q,  state_d;
    logic [DATA_WIDTH-1:0]   req_q,    req_d;
    logic [PTR_W-1:0]        ptr_q,    ptr_d;
    logic [PTR_W-1:0]        winner_q, winner_d;
    logic [DATA_WIDTH-1:0]   gnt_q,    gnt_d;
    logic [DATA_WIDTH-1:0]   done_q,   done_d;
    logic                    drive_q,  drive_d;
    logic                    err_q,    err_d;
    logic [SET_W-1:0]        setup_q,  setup_d;
    logic [7:0]              tmo_q,    tmo_d;
    logic                    init_q,   init_d;

    logic [SYNC_STAGES-1:0]  free_sync_q, free_sync_d;
    logic [SYNC_STAGES-1:0]  nxt_sync_q,  nxt_sync_d;
    logic                    free_ph_q,   free_ph_d;
    logic                    nxt_ph_q,    nxt_ph_d;

    logic                    free_s;
    logic                    nxt_s;
    logic                    free_ev;
    logic                    nxt_ev;
    logic [PTR_W-1:0]        arb_idx;
    logic [PTR_W-1:0]        ptr_inc;

    // First requester at or above ptr, wrapping past the top index.
    function automatic logic [PTR_W-1:0] rr_pick(
        input logic [DATA_WIDTH-1:0] req,
        input logic [PTR_W-1:0]      ptr
    );
        int unsigned pos;
        logic        found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            pos = 32'(ptr) + i;
            if (pos >= DATA_WIDTH) begin
                pos = pos - DATA_WIDTH;
            end
            if (!found && req[pos[PTR_W-1:0]]) begin
                found   = 1'b1;
                rr_pick = pos[PTR_W-1:0];
            end
        end
    endfunction

    // Synchronizer chains: shift toward the MSB; the MSB is the synced value.
    always_comb begin
        free_sync_d = {free_sync_q[SYNC_STAGES-2:0], i_free};
        nxt_sync_d  = {nxt_sync_q[SYNC_STAGES-2:0],  i_freeNext};
    end

    assign free_s  = free_sync_q[SYNC_STAGES-1];
    assign nxt_s   = nxt_sync_q[SYNC_STAGES-1];
    // A 2-phase event is any difference between the synced level and the
    // phase last accepted.
    assign free_ev = free_s ^ free_ph_q;
    assign nxt_ev  = nxt_s ^ nxt_ph_q;

    assign arb_idx = rr_pick(req_q, ptr_q);
    assign ptr_inc = (winner_q == LAST_IDX) ? '0 : winner_q + 1'b1;

    // Requests are registered once before IDLE looks at them. This gives
    // a grant two edges after the edge on which the request is first
    // present.
    assign req_d = i_req;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        winner_d  = winner_q;
        gnt_d     = gnt_q;
        done_d    = '0;
        drive_d   = drive_q;
        err_d     = err_q;
        setup_d   = setup_q;
        tmo_d     = tmo_q;
        free_ph_d = free_ph_q;
        nxt_ph_d  = nxt_ph_q;
        init_d    = 1'b1;

        // First cycle out of reset: adopt whatever the chains now show.
        if (!init_q) begin
            free_ph_d = free_s;
            nxt_ph_d  = nxt_s;
        end

        unique case (state_q)
            IDLE: begin
                // Stray selector edges are absorbed while no transaction is
                // in flight.
                free_ph_d = free_s;
                nxt_ph_d  = nxt_s;
                if (|req_q) begin
                    state_d = ARB;
                end
            end

            ARB: begin
                free_ph_d = free_s;
                nxt_ph_d  = nxt_s;
                if (|req_q) begin
                    winner_d = arb_idx;
                    gnt_d    = DATA_WIDTH'(1) << arb_idx;
                    setup_d  = '0;
                    state_d  = SETUP;
                end else begin
                    state_d  = IDLE;
                end
            end

            SETUP: begin
                free_ph_d = free_s;
                nxt_ph_d  = nxt_s;
                if (setup_q == SETUP_LAST) begin
                    drive_d = ~drive_q;
                    tmo_d   = '0;
                    state_d = WAIT_FREE;
                end else begin
                    setup_d = setup_q + 1'b1;
                end
            end

            WAIT_FREE: begin
                if (free_ev) begin
                    free_ph_d = free_s;
                    if (nxt_ev) begin
                        // Both acknowledgements in one cycle: skip WAIT_DONE.
                        nxt_ph_d = nxt_s;
                        done_d   = gnt_q;
                        gnt_d    = '0;
                        ptr_d    = ptr_inc;
                        state_d  = COMPLETE;
                    end else begin
                        state_d  = WAIT_DONE;
                    end
                end else begin
                    tmo_d = tmo_q + 8'd1;
                    if (tmo_q + 8'd1 == TMO_LIMIT) begin
                        err_d   = 1'b1;
                        gnt_d   = '0;
                        state_d = ERROR;
                    end
                end
            end

            WAIT_DONE: begin
                if (nxt_ev) begin
                    nxt_ph_d = nxt_s;
                    done_d   = gnt_q;
                    gnt_d    = '0;
                    ptr_d    = ptr_inc;
                    state_d  = COMPLETE;
                end else begin
                    // The budget covers WAIT_FREE and WAIT_DONE together.
                    tmo_d = tmo_q + 8'd1;
                    if (tmo_q + 8'd1 == TMO_LIMIT) begin
                        err_d   = 1'b1;
                        gnt_d   = '0;
                        state_d = ERROR;
                    end
                end
            end

            COMPLETE: begin
                free_ph_d = free_s;
                nxt_ph_d  = nxt_s;
                state_d   = IDLE;
            end

            ERROR: begin
                if (i_clr) begin
                    err_d     = 1'b0;
                    free_ph_d = free_s;
                    nxt_ph_d  = nxt_s;
                    state_d   = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            req_q       <= '0;
            ptr_q       <= '0;
            winner_q    <= '0;
            gnt_q       <= '0;
            done_q      <= '0;
            drive_q     <= 1'b0;
            err_q       <= 1'b0;
            setup_q     <= '0;
            tmo_q       <= '0;
            init_q      <= 1'b0;
            free_sync_q <= '0;
            nxt_sync_q  <= '0;
            free_ph_q   <= 1'b0;
            nxt_ph_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            ptr_q       <= ptr_d;
            winner_q    <= winner_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            drive_q     <= drive_d;
            err_q       <= err_d;
            setup_q     <= setup_d;
            tmo_q       <= tmo_d;
            init_q      <= init_d;
            free_sync_q <= free_sync_d;
            nxt_sync_q  <= nxt_sync_d;
            free_ph_q   <= free_ph_d;
            nxt_ph_q    <= nxt_ph_d;
        end
    end

    assign o_gnt   = gnt_q;
    assign o_valid = gnt_q;
    assign o_done  = done_q;
    assign o_drive = drive_q;
    assign o_busy  = (state_q != IDLE);
    assign o_err   = err_q;

endmodule

// File: tb/tb_sel_rr_scheduler.sv
// Self-checking bench for sel_rr_scheduler. The bench acts as the selector:
// it answers each o_drive toggle with free / freeNext edges. A round-robin
// model predicts every grant, and the predictions go into a scoreboard
// queue.

module tb_sel_rr_scheduler;

    localparam int W  = 32;
    localparam int SS = 2;
    localparam int SC = 2;
    localparam int TO = 255;

    logic         clk;
    logic         rst;
    logic [W-1:0] i_req;
    logic [W-1:0] o_gnt;
    logic [W-1:0] o_done;
    logic [W-1:0] o_valid;
    logic         o_drive;
    logic         i_free;
    logic         i_freeNext;
    logic         o_busy;
    logic         o_err;
    logic         i_clr;

    sel_rr_scheduler #(
        .DATA_WIDTH   (W),
        .SYNC_STAGES  (SS),
        .SETUP_CYCLES (SC),
        .TIMEOUT      (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_req      (i_req),
        .o_gnt      (o_gnt),
        .o_done     (o_done),
        .o_valid    (o_valid),
        .o_drive    (o_drive),
        .i_free     (i_free),
        .i_freeNext (i_freeNext),
        .o_busy     (o_busy),
        .o_err      (o_err),
        .i_clr      (i_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_mis = 0;

    logic [W-1:0] exp_q[$];
    int           mdl_ptr;
    logic         mdl_drive;

    logic [W-1:0] obs_gnt, obs_valid, obs_done, obs_gnt_at_done, obs_done_after;
    int           obs_lat, obs_setup, obs_done_lat;
    bit           obs_stable, obs_drive_ok, obs_early_done;

    // Round-robin reference: rotate so ptr sits at bit 0, take the lowest set bit.
    function automatic int model_pick(input logic [W-1:0] req, input int ptr);
        logic [W-1:0] rot;
        rot = (req >> ptr) | (req << (W - ptr));
        for (int j = 0; j < W; j++) begin
            if (rot[j]) return (ptr + j) % W;
        end
        return -1;
    endfunction

    // Selector stand-in. mode 0: free, then freeNext later; mode 1: both
    // together; mode 2: never answer. Records observations for the caller.
    task automatic serve(input logic [W-1:0] req, input int mode, input bit drop);
        int idx;
        @(negedge clk);
        i_req = req;
        idx = model_pick(req, mdl_ptr);
        exp_q.push_back(W'(1) << idx);
        obs_early_done = 1'b0;
        obs_done       = '0;
        obs_done_lat   = 0;
        obs_lat        = 0;
        while (o_gnt === '0 && obs_lat < 20) begin
            @(negedge clk);
            obs_lat++;
        end
        obs_gnt    = o_gnt;
        obs_valid  = o_valid;
        obs_setup  = 0;
        obs_stable = 1'b1;
        while (o_drive === mdl_drive && obs_setup < 20) begin
            if (o_valid !== obs_gnt) obs_stable = 1'b0;
            obs_setup++;
            @(negedge clk);
        end
        mdl_drive    = ~mdl_drive;
        obs_drive_ok = (o_drive === mdl_drive) && (o_valid === obs_gnt);
        if (mode == 2) return;
        repeat (2) @(negedge clk);
        i_free = ~i_free;
        if (mode == 1) begin
            i_freeNext = ~i_freeNext;
        end else begin
            repeat (4) begin
                @(negedge clk);
                if (o_done !== '0) obs_early_done = 1'b1;
            end
            i_freeNext = ~i_freeNext;
        end
        while (o_done === '0 && obs_done_lat < 20) begin
            @(negedge clk);
            obs_done_lat++;
        end
        obs_done        = o_done;
        obs_gnt_at_done = o_gnt;
        if (drop) i_req = '0;
        mdl_ptr = (idx + 1) % W;
        @(negedge clk);
        obs_done_after = o_done;
    endtask

    task automatic test_reset();
        rst        = 1'b0;
        i_req      = '0;
        i_free     = 1'b0;
        i_freeNext = 1'b0;
        i_clr      = 1'b0;
        mdl_ptr    = 0;
        mdl_drive  = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({o_gnt, o_valid, o_done} !== '0) begin
            n_mis++;
            $display("FAIL reset_vectors: got %h/%h/%h expected 0", o_gnt, o_valid, o_done);
        end
        n_vec++;
        if ({o_drive, o_busy, o_err} !== 3'b000) begin
            n_mis++;
            $display("FAIL reset_flags: got drive/busy/err=%b%b%b expected 000", o_drive, o_busy, o_err);
        end
        rst = 1'b1;
        repeat (5) @(negedge clk);
        n_vec++;
        if (o_busy !== 1'b0 || o_gnt !== '0) begin
            n_mis++;
            $display("FAIL reset_idle: got busy=%b gnt=%h expected 0/0", o_busy, o_gnt);
        end
    endtask

    task automatic test_fairness();
        logic [W-1:0] exp;
        int           drives;
        drives = 0;
        for (int i = 0; i < 33; i++) begin
            serve('1, 0, i == 32);
            exp = exp_q.pop_front();
            n_vec++;
            if (obs_gnt !== exp || !$onehot(obs_gnt)) begin
                n_mis++;
                $display("FAIL fair_gnt[%0d]: got %h expected %h", i, obs_gnt, exp);
            end
            n_vec++;
            if (obs_gnt !== (W'(1) << (i % W))) begin
                n_mis++;
                $display("FAIL fair_order[%0d]: got %h expected bit %0d", i, obs_gnt, i % W);
            end
            n_vec++;
            if (obs_done !== exp) begin
                n_mis++;
                $display("FAIL fair_done[%0d]: got %h expected %h", i, obs_done, exp);
            end
            if (obs_drive_ok) drives++;
        end
        n_vec++;
        if (drives != 33) begin
            n_mis++;
            $display("FAIL fair_drive_toggles: got %0d expected 33", drives);
        end
    endtask

    task automatic test_single();
        logic [W-1:0] exp;
        serve(32'h0000_0008, 0, 1'b1);
        exp = exp_q.pop_front();
        n_vec++;
        if (obs_gnt !== exp || obs_gnt !== 32'h0000_0008) begin
            n_mis++;
            $display("FAIL single_gnt: got %h expected %h", obs_gnt, exp);
        end
        n_vec++;
        if (obs_valid !== 32'h0000_0008) begin
            n_mis++;
            $display("FAIL single_valid: got %h expected 00000008", obs_valid);
        end
        n_vec++;
        if (obs_lat != 3) begin
            n_mis++;
            $display("FAIL single_gnt_latency: got %0d expected 3", obs_lat);
        end
        n_vec++;
        if (obs_setup != SC || !obs_stable) begin
            n_mis++;
            $display("FAIL single_setup: got %0d cycles stable=%0d expected %0d stable=1", obs_setup, obs_stable, SC);
        end
        n_vec++;
        if (!obs_drive_ok) begin
            n_mis++;
            $display("FAIL single_drive: got %b expected %b", o_drive, mdl_drive);
        end
        n_vec++;
        if (obs_early_done) begin
            n_mis++;
            $display("FAIL single_early_done: got done before freeNext expected none");
        end
        n_vec++;
        if (obs_done !== 32'h0000_0008 || obs_done_lat != SS + 1) begin
            n_mis++;
            $display("FAIL single_done: got %h after %0d expected 00000008 after %0d", obs_done, obs_done_lat, SS + 1);
        end
        n_vec++;
        if (obs_gnt_at_done !== '0 || obs_done_after !== '0) begin
            n_mis++;
            $display("FAIL single_done_pulse: got gnt=%h next_done=%h expected 0/0", obs_gnt_at_done, obs_done_after);
        end
        // Pointer is now 4: bits 3 and 4 requested, bit 4 wins.
        serve(32'h0000_0018, 0, 1'b1);
        exp = exp_q.pop_front();
        n_vec++;
        if (obs_gnt !== exp || obs_gnt !== 32'h0000_0010) begin
            n_mis++;
            $display("FAIL single_ptr4: got %h expected 00000010", obs_gnt);
        end
    endtask

    task automatic test_wrap();
        logic [W-1:0] exp;
        serve(32'h4000_0000, 0, 1'b1);
        exp = exp_q.pop_front();
        n_vec++;
        if (obs_gnt !== exp) begin
            n_mis++;
            $display("FAIL wrap_setup: got %h expected %h", obs_gnt, exp);
        end
        serve(32'h8000_0001, 0, 1'b0);
        exp = exp_q.pop_front();
        n_vec++;
        if (obs_gnt !== exp || obs_gnt !== 32'h8000_0000) begin
            n_mis++;
            $display("FAIL wrap_first: got %h expected 80000000", obs_gnt);
        end
        serve(32'h8000_0001, 0, 1'b1);
        exp = exp_q.pop_front();
        n_vec++;
        if (obs_gnt !== exp || obs_gnt !== 32'h0000_0001 || obs_done !== 32'h0000_0001) begin
            n_mis++;
            $display("FAIL wrap_second: got gnt=%h done=%h expected 00000001", obs_gnt, obs_done);
        end
    endtask

    task automatic test_simultaneous();
        logic [W-1:0] exp;
        serve(32'h0000_0100, 1, 1'b1);
        exp = exp_q.pop_front();
        n_vec++;
        if (obs_gnt !== exp || obs_done !== exp) begin
            n_mis++;
            $display("FAIL simul_gnt_done: got %h/%h expected %h", obs_gnt, obs_done, exp);
        end
        n_vec++;
        if (obs_done_lat != SS + 1 || obs_done_after !== '0) begin
            n_mis++;
            $display("FAIL simul_latency: got %0d expected %0d", obs_done_lat, SS + 1);
        end
    endtask

    task automatic test_timeout();
        logic [W-1:0] exp;
        int           n;
        bit           done_seen;
        serve(32'h0000_0002, 2, 1'b0);
        exp = exp_q.pop_front();
        n_vec++;
        if (obs_gnt !== exp || !obs_drive_ok) begin
            n_mis++;
            $display("FAIL tmo_gnt: got %h expected %h", obs_gnt, exp);
        end
        n         = 0;
        done_seen = 1'b0;
        while (o_err !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
            if (o_done !== '0) done_seen = 1'b1;
        end
        n_vec++;
        if (n != TO) begin
            n_mis++;
            $display("FAIL tmo_cycles: got %0d expected %0d", n, TO);
        end
        n_vec++;
        if (o_valid !== '0 || o_gnt !== '0 || done_seen || o_busy !== 1'b1) begin
            n_mis++;
            $display("FAIL tmo_outputs: got valid=%h gnt=%h done_seen=%0d busy=%b expected 0/0/0/1", o_valid, o_gnt, done_seen, o_busy);
        end
        i_req = '0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (o_err !== 1'b1) begin
            n_mis++;
            $display("FAIL tmo_sticky: got %b expected 1", o_err);
        end
        i_clr = 1'b1;
        @(negedge clk);
        i_clr = 1'b0;
        n_vec++;
        if (o_err !== 1'b0 || o_busy !== 1'b0) begin
            n_mis++;
            $display("FAIL tmo_clear: got err=%b busy=%b expected 0/0", o_err, o_busy);
        end
        // Pointer must not have moved past the timed-out winner (bit 1).
        serve(32'h0000_0006, 0, 1'b1);
        exp = exp_q.pop_front();
        n_vec++;
        if (obs_gnt !== exp || obs_gnt !== 32'h0000_0002 || obs_done !== 32'h0000_0002) begin
            n_mis++;
            $display("FAIL tmo_recover: got gnt=%h done=%h expected 00000002", obs_gnt, obs_done);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] exp;
        int           w;
        bit           done_seen;
        @(negedge clk);
        i_req = 32'h0000_0010;
        w = 0;
        while (o_gnt === '0 && w < 20) begin
            @(negedge clk);
            w++;
        end
        w = 0;
        while (o_drive === mdl_drive && w < 20) begin
            @(negedge clk);
            w++;
        end
        repeat (2) @(negedge clk);
        i_free = ~i_free;
        repeat (5) @(negedge clk);
        n_vec++;
        if (o_gnt !== 32'h0000_0010 || o_busy !== 1'b1 || o_done !== '0) begin
            n_mis++;
            $display("FAIL mid_in_flight: got gnt=%h busy=%b done=%h expected 00000010/1/0", o_gnt, o_busy, o_done);
        end
        #2 rst = 1'b0;
        #1;
        n_vec++;
        if ({o_gnt, o_valid, o_done, o_drive, o_busy, o_err} !== '0) begin
            n_mis++;
            $display("FAIL mid_async_reset: got gnt=%h valid=%h drive=%b busy=%b expected all 0", o_gnt, o_valid, o_drive, o_busy);
        end
        i_req = '0;
        repeat (2) @(negedge clk);
        rst       = 1'b1;
        mdl_ptr   = 0;
        mdl_drive = 1'b0;
        repeat (3) @(negedge clk);
        i_freeNext = ~i_freeNext;
        done_seen  = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (o_done !== '0 || o_busy !== 1'b0) done_seen = 1'b1;
        end
        n_vec++;
        if (done_seen) begin
            n_mis++;
            $display("FAIL mid_stale_edge: got activity after stale freeNext expected none");
        end
        serve('1, 0, 1'b1);
        exp = exp_q.pop_front();
        n_vec++;
        if (obs_gnt !== exp || obs_gnt !== 32'h0000_0001 || obs_done !== 32'h0000_0001 || !obs_drive_ok) begin
            n_mis++;
            $display("FAIL mid_restart: got gnt=%h done=%h drive_ok=%0d expected 00000001", obs_gnt, obs_done, obs_drive_ok);
        end
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_single();
        test_wrap();
        test_simultaneous();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
